led_frame_parser: RTL and testbench
===================================

// Module: led_frame_parser
// PURPOSE
//   Parametrised UART command-frame parser for multi-channel LED control. It sits behind
//   the UART receiver and consumes one byte per rx_done pulse. A byte-level FSM validates
//   each frame and updates the Ctrl/time_set registers of one addressed channel. Malformed,
//   out-of-range and stalled frames are flagged and never change any channel register.
// PARAMETERS
//   N_CH         4          number of LED channels (>=1); CH_W = (N_CH>1) ? $clog2(N_CH) : 1
//   TIME_BYTES   4          time_set bytes per frame (1..8); TIME_W = 8*TIME_BYTES
//   HDR0         8'h55      first header byte
//   HDR1         8'hA5      second header byte
//   TAIL         8'hF0      frame tail byte
//   TIMEOUT_CYC  1_000_000  max Clk cycles between bytes inside a frame; 0 = watchdog disabled
// PORTS
//   Clk        in   1           system clock; all logic on the rising edge
//   Reset_n    in   1           asynchronous, active-low reset
//   rx_data    in   8           received byte; valid only while rx_done=1
//   rx_done    in   1           one-cycle strobe, one per received byte
//   Ctrl       out  N_CH*8      channel k occupies bits [8k+7:8k]
//   time_set   out  N_CH*TIME_W channel k occupies bits [TIME_W*k+TIME_W-1:TIME_W*k]
//   upd_valid  out  1           one-cycle pulse: a channel register was updated
//   upd_ch     out  CH_W        index of the updated channel; holds until the next update
//   frame_err  out  1           one-cycle pulse: frame rejected (bad tail/ch/sum or timeout)
// BEHAVIOUR
//   - Reset: Ctrl, time_set, upd_ch, internal shadows = 0; upd_valid = frame_err = 0; FSM in S_HDR0.
//   - Frame order: HDR0, HDR1, CH, CTRL, T[0]..T[TIME_BYTES-1] (LSB first), [SUM], TAIL.
//   - FSM advances only on cycles with rx_done=1; rx_data is ignored otherwise.
//   - S_HDR0: byte==HDR0 -> S_HDR1; any other byte stays in S_HDR0 with no error.
//   - S_HDR1: byte==HDR1 -> S_CH; byte==HDR0 -> stay in S_HDR1; else -> S_HDR0, no error.
//   - S_CH:   latch CH -> S_CTRL. S_CTRL: latch CTRL -> S_TIME; byte counter cleared.
//   - S_TIME: latch T[i] into shadow bits [8i+7:8i]; after byte TIME_BYTES-1 -> S_SUM,
//     or -> S_TAIL when the checksum option is compiled out.
//   - S_TAIL: always returns to S_HDR0. Accept iff byte==TAIL, CH<N_CH and checksum ok.
//     Accept: Ctrl[CH] <= CTRL, time_set[CH] <= shadow, upd_ch <= CH, upd_valid=1.
//     Reject: frame_err=1; no channel register changes.
//   - Outputs update on the clock edge that samples the tail byte (zero extra latency).
//     upd_valid and frame_err are registered and asserted for exactly the next cycle.
//   - Only the addressed channel changes. Other channels hold their values.
//   - Watchdog: in any state except S_HDR0, a gap of TIMEOUT_CYC cycles with no rx_done
//     forces S_HDR0 and pulses frame_err. The counter clears on every rx_done.
//     If a byte arrives on the expiry cycle, the byte wins: it is processed and no timeout occurs.
//   - A header in the payload is treated as data. No resync happens until the frame finishes or times out.
//   - Reset mid-frame discards the partial frame and returns all outputs to their reset values.
// CONFIGURATION
//   LED_FRAME_CHECKSUM_EN defined: adds state S_SUM between S_TIME and S_TAIL.
//     The SUM byte must equal (CH + CTRL + sum of T[i]) mod 256. A mismatch is recorded,
//     and the frame is rejected at S_TAIL with frame_err (the tail is still consumed).
//   LED_FRAME_CHECKSUM_EN undefined: there is no S_SUM state. Frame length is 5+TIME_BYTES bytes.
// STRUCTURE
//   Package led_cmd_pkg: FSM state encoding (S_HDR0,S_HDR1,S_CH,S_CTRL,S_TIME,S_SUM,S_TAIL),
//   default HDR0/HDR1/TAIL byte constants, and a checksum-width localparam.
//   Sub-module led_rx_watchdog: inter-byte timeout counter. It takes the TIMEOUT_CYC
//   parameter, has inputs clr and arm, and output expire.
//   The FSM, shadow registers and per-channel register file stay in the top module.
// TESTING
//   T1 No checksum, N_CH=4, TIME_BYTES=4: send 55 A5 02 3C 10 27 00 00 F0.
//      Expect Ctrl[2]=8'h3C, time_set[2]=32'h0000_2710, upd_ch=2, one upd_valid pulse;
//      channels 0, 1 and 3 unchanged.
//   T2 Send 55 55 A5 01 07 01 00 00 00 F0 -> Ctrl[1]=8'h07, time_set[1]=1 (HDR0 repeat resync).
//   T3 Send 55 A5 04 11 01 02 03 04 F0 (CH out of range) -> frame_err pulse, no upd_valid,
//      all registers unchanged.
//   T4 Send a valid frame with tail 8'hF1 -> frame_err. Then send a valid frame
//      immediately -> accepted normally.
//   T5 TIMEOUT_CYC=100: send 55 A5 00, idle 100 cycles -> frame_err at the expiry.
//      Next, 03 AA 00 00 00 F0 must not update anything (parser is in S_HDR0).
//   T6 LED_FRAME_CHECKSUM_EN: 55 A5 01 02 03 04 05 06 15 F0 -> accepted.
//      The same frame with SUM=16 -> frame_err and no update.

Source files
------------

// File: rtl/led_cmd_pkg.sv
// Shared definitions for the LED command-frame parser: FSM states, default framing bytes, checksum width.
package led_cmd_pkg;

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_CH,
    S_CTRL,
    S_TIME,
    S_SUM,
    S_TAIL
  } state_t;

  localparam logic [7:0] DEF_HDR0 = 8'h55;
  localparam logic [7:0] DEF_HDR1 = 8'hA5;
  localparam logic [7:0] DEF_TAIL = 8'hF0;

  localparam int unsigned SUM_W = 8;

endpackage

// File: rtl/led_rx_watchdog.sv
// Inter-byte timeout: expire pulses on the TIMEOUT_CYC-th consecutive armed cycle without clr.
module led_rx_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic clr,
  input  logic arm,
  output logic expire
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      logic unused_in;
      assign unused_in = clr ^ arm ^ Clk ^ Reset_n;
      assign expire    = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

      logic [CW-1:0] cnt;

      // A byte on the expiry cycle suppresses the timeout.
      assign expire = arm && !clr && (cnt == LAST);

      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)                   cnt <= '0;
        else if (clr || !arm || expire) cnt <= '0;
        else                            cnt <= cnt + 1'b1;
      end
    end
  endgenerate

endmodule

// File: rtl/led_frame_parser.sv
// UART command-frame parser updating per-channel Ctrl/time_set registers.
// Optional SUM byte before the tail when LED_FRAME_CHECKSUM_EN is defined.
module led_frame_parser
  import led_cmd_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned TIME_BYTES  = 4,
  parameter logic [7:0]  HDR0        = DEF_HDR0,
  parameter logic [7:0]  HDR1        = DEF_HDR1,
  parameter logic [7:0]  TAIL        = DEF_TAIL,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int unsigned TIME_W     = 8 * TIME_BYTES
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_done,
  output logic [N_CH*8-1:0]        Ctrl,
  output logic [N_CH*TIME_W-1:0]   time_set,
  output logic                     upd_valid,
  output logic [CH_W-1:0]          upd_ch,
  output logic                     frame_err
);

  localparam int unsigned BC_W = (TIME_BYTES > 1) ? $clog2(TIME_BYTES) : 1;

  state_t            state, state_nxt;
  logic [7:0]        ch_q, ctrl_q;
  logic [TIME_W-1:0] shadow;
  logic [BC_W-1:0]   byte_cnt;
  logic              last_time, ch_ok, sum_ok;
  logic              expire, accept, reject;

  assign last_time = (byte_cnt == BC_W'(TIME_BYTES - 1));
  assign ch_ok     = ({24'd0, ch_q} < N_CH);

  led_rx_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .clr    (rx_done),
    .arm    (state != S_HDR0),
    .expire (expire)
  );

`ifdef LED_FRAME_CHECKSUM_EN
  logic [SUM_W-1:0] sum_q;
  logic             sum_bad;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sum_q   <= '0;
      sum_bad <= 1'b0;
    end else if (rx_done) begin
      case (state)
        S_CH:          begin sum_q <= rx_data; sum_bad <= 1'b0; end
        S_CTRL, S_TIME: sum_q <= sum_q + rx_data;
        S_SUM:         sum_bad <= (rx_data != sum_q);
        default: ;
      endcase
    end
  end

  assign sum_ok = !sum_bad;
`else
  assign sum_ok = 1'b1;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_HDR0;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    if (expire) begin
      state_nxt = S_HDR0;
      reject    = 1'b1;
    end else if (rx_done) begin
      case (state)
        S_HDR0: if (rx_data == HDR0) state_nxt = S_HDR1;
        S_HDR1: begin
          if (rx_data == HDR1)      state_nxt = S_CH;
          else if (rx_data != HDR0) state_nxt = S_HDR0;
        end
        S_CH:   state_nxt = S_CTRL;
        S_CTRL: state_nxt = S_TIME;
        S_TIME: begin
`ifdef LED_FRAME_CHECKSUM_EN
          if (last_time) state_nxt = S_SUM;
`else
          if (last_time) state_nxt = S_TAIL;
`endif
        end
`ifdef LED_FRAME_CHECKSUM_EN
        S_SUM:  state_nxt = S_TAIL;
`endif
        S_TAIL: begin
          state_nxt = S_HDR0;
          if (rx_data == TAIL && ch_ok && sum_ok) accept = 1'b1;
          else                                    reject = 1'b1;
        end
        default: state_nxt = S_HDR0;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ch_q      <= '0;
      ctrl_q    <= '0;
      shadow    <= '0;
      byte_cnt  <= '0;
      Ctrl      <= '0;
      time_set  <= '0;
      upd_ch    <= '0;
      upd_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      upd_valid <= accept;
      frame_err <= reject;
      if (rx_done) begin
        case (state)
          S_CH:   ch_q <= rx_data;
          S_CTRL: begin
            ctrl_q   <= rx_data;
            byte_cnt <= '0;
          end
          S_TIME: begin
            shadow[8*byte_cnt +: 8] <= rx_data;
            byte_cnt                <= byte_cnt + 1'b1;
          end
          default: ;
        endcase
      end
      if (accept) begin
        upd_ch <= ch_q[CH_W-1:0];
        for (int unsigned k = 0; k < N_CH; k++) begin
          if (ch_q == 8'(k)) begin
            Ctrl[8*k +: 8]               <= ctrl_q;
            time_set[TIME_W*k +: TIME_W] <= shadow;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_led_frame_parser.sv
// Scoreboard bench for led_frame_parser (N_CH=4, TIME_BYTES=4, TIMEOUT_CYC=100).
module tb_led_frame_parser;

  localparam int unsigned N_CH        = 4;
  localparam int unsigned TIME_BYTES  = 4;
  localparam int unsigned TIMEOUT_CYC = 100;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic [7:0]   rx_data = '0;
  logic         rx_done = 1'b0;
  logic [31:0]  Ctrl;
  logic [127:0] time_set;
  logic         upd_valid;
  logic [1:0]   upd_ch;
  logic         frame_err;

  typedef struct {
    bit           upd;
    logic [1:0]   ch;
    logic [31:0]  ctrl_all;
    logic [127:0] ts_all;
    string        name;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  logic [31:0]  m_ctrl = '0;
  logic [127:0] m_ts   = '0;
  logic [1:0]   m_ch   = '0;
  int           n_cmp  = 0;
  int           n_bad  = 0;

  led_frame_parser #(
    .N_CH       (N_CH),
    .TIME_BYTES (TIME_BYTES),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .Ctrl     (Ctrl),
    .time_set (time_set),
    .upd_valid(upd_valid),
    .upd_ch   (upd_ch),
    .frame_err(frame_err)
  );

  always #5 Clk = ~Clk;

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge Clk);
    #1;
    rx_done = 1'b0;
    rx_data = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] ch, input logic [7:0] ctrl,
                            input logic [31:0] t, input logic [7:0] tail);
    logic [7:0] s;
    s = ch + ctrl;
    send_byte(8'h55);
    send_byte(8'hA5);
    send_byte(ch);
    send_byte(ctrl);
    for (int i = 0; i < 4; i++) begin
      send_byte(t[8*i +: 8]);
      s = s + t[8*i +: 8];
    end
`ifdef LED_FRAME_CHECKSUM_EN
    send_byte(s);
`endif
    send_byte(tail);
  endtask

  function automatic void expect_upd(input logic [1:0] ch, input logic [7:0] ctrl,
                                     input logic [31:0] ts, input string name);
    exp_t e;
    m_ctrl[8*ch +: 8]  = ctrl;
    m_ts[32*ch +: 32]  = ts;
    m_ch               = ch;
    e.upd = 1'b1; e.ch = m_ch; e.ctrl_all = m_ctrl; e.ts_all = m_ts; e.name = name;
    q.push_back(e);
  endfunction

  function automatic void expect_err(input string name);
    exp_t e;
    e.upd = 1'b0; e.ch = m_ch; e.ctrl_all = m_ctrl; e.ts_all = m_ts; e.name = name;
    q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  always @(negedge Clk) begin
    if (Reset_n && (upd_valid || frame_err)) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: upd_valid=%b frame_err=%b upd_ch=%0d", upd_valid, frame_err, upd_ch);
      end else begin
        mon_e = q.pop_front();
        if (upd_valid !== mon_e.upd || frame_err !== !mon_e.upd || upd_ch !== mon_e.ch ||
            Ctrl !== mon_e.ctrl_all || time_set !== mon_e.ts_all) begin
          n_bad++;
          $display("FAIL %s: got upd=%b err=%b ch=%0d ctrl=%h ts=%h want upd=%b err=%b ch=%0d ctrl=%h ts=%h",
                   mon_e.name, upd_valid, frame_err, upd_ch, Ctrl, time_set,
                   mon_e.upd, !mon_e.upd, mon_e.ch, mon_e.ctrl_all, mon_e.ts_all);
        end
      end
    end
  end

  initial begin
    idle(3);
    check("reset_ctrl", Ctrl, '0);
    check("reset_time_set", time_set, '0);
    check("reset_upd_ch", upd_ch, '0);
    check("reset_upd_valid", upd_valid, '0);
    check("reset_frame_err", frame_err, '0);
    Reset_n = 1'b1;
    idle(2);

    expect_upd(2'd2, 8'h3C, 32'h0000_2710, "T1_basic");
    send_frame(8'h02, 8'h3C, 32'h0000_2710, 8'hF0);
    idle(2);

    expect_upd(2'd1, 8'h07, 32'h0000_0001, "T2_hdr0_repeat");
    send_byte(8'h55);
    send_frame(8'h01, 8'h07, 32'h0000_0001, 8'hF0);
    idle(2);

    expect_err("T3_ch_range");
    send_frame(8'h04, 8'h11, 32'h0403_0201, 8'hF0);
    idle(2);

    expect_err("T4_bad_tail");
    send_frame(8'h03, 8'h5A, 32'hDEAD_BEEF, 8'hF1);
    expect_upd(2'd3, 8'h5A, 32'hDEAD_BEEF, "T4_next_ok");
    send_frame(8'h03, 8'h5A, 32'hDEAD_BEEF, 8'hF0);
    idle(2);

    expect_upd(2'd0, 8'h55, 32'hA555_A555, "hdr_in_payload");
    send_frame(8'h00, 8'h55, 32'hA555_A555, 8'hF0);
    idle(2);

    expect_upd(2'd2, 8'h81, 32'hFFFF_FFFF, "ch2_overwrite");
    send_frame(8'h02, 8'h81, 32'hFFFF_FFFF, 8'hF0);
    idle(2);

    expect_err("T5_timeout");
    send_byte(8'h55);
    send_byte(8'hA5);
    send_byte(8'h00);
    idle(TIMEOUT_CYC - 1);
    check("T5_before_expiry", frame_err, 1'b0);
    idle(1);
    check("T5_at_expiry", frame_err, 1'b1);
    send_byte(8'h03);
    send_byte(8'hAA);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'hF0);
    idle(3);

    // Byte lands on the expiry cycle, so the frame must survive.
    expect_upd(2'd1, 8'hC3, 32'h0000_BEEF, "byte_on_expiry");
    send_byte(8'h55);
    send_byte(8'hA5);
    send_byte(8'h01);
    idle(TIMEOUT_CYC - 1);
    send_byte(8'hC3);
    send_byte(8'hEF);
    send_byte(8'hBE);
    send_byte(8'h00);
    send_byte(8'h00);
`ifdef LED_FRAME_CHECKSUM_EN
    send_byte(8'h71);
`endif
    send_byte(8'hF0);
    idle(2);

    send_byte(8'h55);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h3C);
    Reset_n = 1'b0;
    #1;
    check("midreset_ctrl", Ctrl, '0);
    check("midreset_time_set", time_set, '0);
    check("midreset_upd_ch", upd_ch, '0);
    m_ctrl = '0;
    m_ts   = '0;
    m_ch   = '0;
    idle(2);
    Reset_n = 1'b1;
    idle(1);
    send_byte(8'h10);
    send_byte(8'hF0);
    expect_upd(2'd3, 8'h99, 32'h0102_0304, "after_reset");
    send_frame(8'h03, 8'h99, 32'h0102_0304, 8'hF0);
    idle(2);

`ifdef LED_FRAME_CHECKSUM_EN
    expect_upd(2'd1, 8'h02, 32'h0605_0403, "T6_sum_ok");
    send_byte(8'h55); send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h04); send_byte(8'h05); send_byte(8'h06);
    send_byte(8'h15); send_byte(8'hF0);
    idle(2);
    expect_err("T6_sum_bad");
    send_byte(8'h55); send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h04); send_byte(8'h05); send_byte(8'h06);
    send_byte(8'h16); send_byte(8'hF0);
    idle(2);
`endif

    idle(5);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_events: got %0d left in queue want 0 (next %s)", q.size(), q[0].name);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
